// File: rtl/pll_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding, counter
// width helpers and default timing for the 48 MHz board clock.
package pll_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    HOLD      = 3'd3,
    RUN       = 3'd4
  } pll_state_e;

  localparam int DEF_PLL_RST_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT   = 48000;
  localparam int DEF_STABLE_CYCLES  = 4800;
  localparam int DEF_HOLD_CYCLES    = 64;
  localparam int DEF_CNT_W          = 8;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // One spare bit above clog2 so the terminal compare value always fits.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic per-bit 2-flop synchronizer with synchronous active-high reset to 0.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      always_ff @(posedge clk) begin
        if (srst) begin
          r_meta[gi] <= 1'b0;
          r_sync[gi] <= 1'b0;
        end else begin
          r_meta[gi] <= i_d[gi];
          r_sync[gi] <= r_meta[gi];
        end
      end
    end
  endgenerate

  assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences the PLL reset, waits for a stable synchronized lock, then releases
// the system reset after a hold period; re-sequences on timeout or lock loss.
module pll_reset_sequencer
  import pll_pkg::*;
#(
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             locked,
  output logic             pll_reset,
  output logic             sys_reset,
  output logic             ready,
  output logic [CNT_W-1:0] retry_count,
  output logic [CNT_W-1:0] loss_count,
  output logic [2:0]       state
);

  localparam int MAX_P = max4(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, HOLD_CYCLES);
  localparam int CW    = cnt_width(MAX_P);

  localparam logic [CW-1:0]    C_RST_LAST  = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0]    C_TO_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0]    C_STB_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0]    C_HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]    C_ONE       = CW'(1);
  localparam logic [CNT_W-1:0] C_SAT       = '1;
  localparam logic [CNT_W-1:0] C_EV_ONE    = CNT_W'(1);

  pll_state_e       r_state;
  pll_state_e       w_state_next;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_next;
  logic             w_retry_inc;
  logic             w_loss_inc;
  logic             w_lk;
  logic             r_pll_reset;
  logic             r_sys_reset;
  logic             r_ready;
  logic [CNT_W-1:0] r_retry_count;
  logic [CNT_W-1:0] r_loss_count;

  sync_2ff #(
    .WIDTH(1)
  ) u_lock_sync (
    .clk (clkin),
    .srst(reset),
    .i_d (locked),
    .o_q (w_lk)
  );

  // The single phase counter is cleared on every transition; lock has
  // priority over the timeout when both happen in the same cycle.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + C_ONE;
    w_retry_inc  = 1'b0;
    w_loss_inc   = 1'b0;
    case (r_state)
      PLL_RST: begin
        if (r_cnt == C_RST_LAST) begin
          w_state_next = WAIT_LOCK;
          w_cnt_next   = '0;
        end
      end
      WAIT_LOCK: begin
        if (w_lk) begin
          w_state_next = STABLE;
          w_cnt_next   = '0;
        end else if (r_cnt == C_TO_LAST) begin
          w_state_next = PLL_RST;
          w_cnt_next   = '0;
          w_retry_inc  = 1'b1;
        end
      end
      STABLE: begin
        if (!w_lk) begin
          w_state_next = WAIT_LOCK;
          w_cnt_next   = '0;
        end else if (r_cnt == C_STB_LAST) begin
          w_state_next = HOLD;
          w_cnt_next   = '0;
        end
      end
      HOLD: begin
        if (!w_lk) begin
          w_state_next = PLL_RST;
          w_cnt_next   = '0;
          w_loss_inc   = 1'b1;
        end else if (r_cnt == C_HOLD_LAST) begin
          w_state_next = RUN;
          w_cnt_next   = '0;
        end
      end
      RUN: begin
        w_cnt_next = '0;
        if (!w_lk) begin
          w_state_next = PLL_RST;
          w_loss_inc   = 1'b1;
        end
      end
      default: begin
        w_state_next = PLL_RST;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register itself.
  always_ff @(posedge clkin) begin
    if (reset) begin
      r_state       <= PLL_RST;
      r_cnt         <= '0;
      r_pll_reset   <= 1'b1;
      r_sys_reset   <= 1'b1;
      r_ready       <= 1'b0;
      r_retry_count <= '0;
      r_loss_count  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_pll_reset <= (w_state_next == PLL_RST);
      r_sys_reset <= (w_state_next != RUN);
      r_ready     <= (w_state_next == RUN);
      if (w_retry_inc && (r_retry_count != C_SAT)) begin
        r_retry_count <= r_retry_count + C_EV_ONE;
      end
      if (w_loss_inc && (r_loss_count != C_SAT)) begin
        r_loss_count <= r_loss_count + C_EV_ONE;
      end
    end
  end

  assign pll_reset   = r_pll_reset;
  assign sys_reset   = r_sys_reset;
  assign ready       = r_ready;
  assign retry_count = r_retry_count;
  assign loss_count  = r_loss_count;
  assign state       = r_state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: a phase/age reference model pushes
// the expected outputs for every edge, and a negedge monitor pops and compares.
module tb_pll_reset_sequencer;

  localparam int T_RST = 4;
  localparam int T_TO  = 20;
  localparam int T_ST  = 8;
  localparam int T_HD  = 5;
  localparam int SAT   = 255;

  typedef struct {
    logic       pr;
    logic       sr;
    logic       rd;
    logic [7:0] rc;
    logic [7:0] lc;
    logic [2:0] st;
    int         edge_no;
  } exp_t;

  logic       clkin = 1'b0;
  logic       reset;
  logic       locked;
  logic       pll_reset;
  logic       sys_reset;
  logic       ready;
  logic [7:0] retry_count;
  logic [7:0] loss_count;
  logic [2:0] state;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   edge_n = 0;

  // Reference model: current phase, cycles spent in it, lock pipeline, event counts.
  int m_ph, m_age, m_s1, m_s2, m_rc, m_lc;

  // Latency probe for the clean-lock scenario.
  bit lat_arm = 0;
  int e_lock  = -1;
  int e_ready = -1;

  always #5 clkin = ~clkin;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(T_RST),
    .LOCK_TIMEOUT  (T_TO),
    .STABLE_CYCLES (T_ST),
    .HOLD_CYCLES   (T_HD),
    .CNT_W         (8)
  ) dut (
    .clkin      (clkin),
    .reset      (reset),
    .locked     (locked),
    .pll_reset  (pll_reset),
    .sys_reset  (sys_reset),
    .ready      (ready),
    .retry_count(retry_count),
    .loss_count (loss_count),
    .state      (state)
  );

  function automatic int sat_inc(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  task automatic enter(input int ph);
    m_ph  = ph;
    m_age = 0;
  endtask

  task automatic model_step(input bit r, input bit l);
    int lk;
    if (r) begin
      m_ph = 0; m_age = 0; m_s1 = 0; m_s2 = 0; m_rc = 0; m_lc = 0;
    end else begin
      lk   = m_s2;
      m_s2 = m_s1;
      m_s1 = l;
      m_age++;
      case (m_ph)
        0: if (m_age == T_RST) enter(1);
        1: begin
          if (lk != 0) enter(2);
          else if (m_age == T_TO) begin enter(0); m_rc = sat_inc(m_rc); end
        end
        2: begin
          if (lk == 0) enter(1);
          else if (m_age == T_ST) enter(3);
        end
        3: begin
          if (lk == 0) begin enter(0); m_lc = sat_inc(m_lc); end
          else if (m_age == T_HD) enter(4);
        end
        default: if (lk == 0) begin enter(0); m_lc = sat_inc(m_lc); end
      endcase
    end
  endtask

  // One clock cycle of stimulus: inputs are stable across the edge, the model
  // advances with the same inputs and the expectation goes to the scoreboard.
  task automatic cyc(input bit r, input bit l);
    exp_t e;
    reset  = r;
    locked = l;
    @(posedge clkin);
    edge_n++;
    if (lat_arm && l && !r && e_lock < 0) e_lock = edge_n;
    model_step(r, l);
    e.pr = (m_ph == 0);
    e.sr = (m_ph != 4);
    e.rd = (m_ph == 4);
    e.rc = 8'(m_rc);
    e.lc = 8'(m_lc);
    e.st = 3'(m_ph);
    e.edge_no = edge_n;
    exp_q.push_back(e);
    #2;
  endtask

  task automatic cycles(input int n, input bit r, input bit l);
    for (int i = 0; i < n; i++) cyc(r, l);
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (edge %0d)", name, act, req, edge_n);
    end
  endtask

  always @(negedge clkin) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (pll_reset !== e.pr || sys_reset !== e.sr || ready !== e.rd ||
          retry_count !== e.rc || loss_count !== e.lc || state !== e.st) begin
        n_bad++;
        $display("FAIL outputs edge %0d: got st=%0d pr=%b sr=%b rd=%b rc=%0d lc=%0d, required st=%0d pr=%b sr=%b rd=%b rc=%0d lc=%0d",
                 e.edge_no, state, pll_reset, sys_reset, ready, retry_count, loss_count,
                 e.st, e.pr, e.sr, e.rd, e.rc, e.lc);
      end
      if (lat_arm && ready === 1'b1 && e_ready < 0) e_ready = e.edge_no;
    end
  end

  initial begin
    int len;
    bit l;
    reset  = 1'b1;
    locked = 1'b0;

    // Clean lock
    cycles(3, 1'b1, 1'b0);
    cycles(10, 1'b0, 1'b0);
    lat_arm = 1;
    cycles(30, 1'b0, 1'b1);
    lat_arm = 0;
    // RUN is entered on the 16th edge counting the first edge that samples locked=1.
    chk("lock_to_ready_latency", e_ready - e_lock, 15);
    chk("clean_lock_ready", int'(ready), 1);
    $display("scenario clean_lock: edge=%0d lock_edge=%0d ready_edge=%0d", edge_n, e_lock, e_ready);

    // Loss in RUN
    cycles(5, 1'b0, 1'b0);
    cycles(40, 1'b0, 1'b1);
    chk("loss_count_after_drop", int'(loss_count), 1);
    chk("relock_ready", int'(ready), 1);
    $display("scenario loss_in_run: edge=%0d loss=%0d", edge_n, loss_count);

    // Timeout retry
    cycles(2, 1'b1, 1'b0);
    chk("reset_state", int'(state), 0);
    chk("reset_loss_count", int'(loss_count), 0);
    cycles(60, 1'b0, 1'b0);
    cycles(40, 1'b0, 1'b1);
    chk("retry_count_after_timeouts", int'(retry_count), 2);
    chk("timeout_then_ready", int'(ready), 1);
    $display("scenario timeout_retry: edge=%0d retry=%0d", edge_n, retry_count);

    // Stability glitch
    cycles(2, 1'b1, 1'b0);
    cycles(6, 1'b0, 1'b0);
    cycles(6, 1'b0, 1'b1);
    chk("glitch_in_stable", int'(state), 2);
    cycles(3, 1'b0, 1'b0);
    cycles(40, 1'b0, 1'b1);
    chk("glitch_retry_count", int'(retry_count), 0);
    chk("glitch_loss_count", int'(loss_count), 0);
    $display("scenario stable_glitch: edge=%0d state=%0d", edge_n, state);

    // Mid-operation reset during HOLD
    cycles(2, 1'b1, 1'b0);
    cycles(6, 1'b0, 1'b0);
    cycles(12, 1'b0, 1'b1);
    chk("pre_reset_in_hold", int'(state), 3);
    cycles(1, 1'b1, 1'b1);
    chk("mid_reset_sys_reset", int'(sys_reset), 1);
    chk("mid_reset_pll_reset", int'(pll_reset), 1);
    cycles(40, 1'b0, 1'b1);
    chk("mid_reset_restart_ready", int'(ready), 1);
    $display("scenario mid_reset: edge=%0d state=%0d", edge_n, state);

    // Saturation of retry_count
    cycles(1, 1'b1, 1'b0);
    cycles(300 * (T_RST + T_TO) + 40, 1'b0, 1'b0);
    chk("retry_saturation", int'(retry_count), SAT);
    $display("scenario saturation: edge=%0d retry=%0d", edge_n, retry_count);

    // Randomized lock behaviour with occasional resets
    cycles(1, 1'b1, 1'b0);
    for (int k = 0; k < 120; k++) begin
      if ($urandom_range(0, 29) == 0) begin
        cycles(1, 1'b1, 1'b0);
      end else begin
        len = $urandom_range(1, 40);
        l   = ($urandom_range(0, 3) != 0);
        cycles(len, 1'b0, l);
      end
    end
    $display("scenario random: edge=%0d retry=%0d loss=%0d", edge_n, retry_count, loss_count);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clkin);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
